// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the memory stage: FSM encoding, poison data
// and the MEM/WB register layout with its reset and bubble values.
package cpu_pkg;

   localparam logic [1:0] ST_IDLE_C   = 2'd0;
   localparam logic [1:0] ST_ACCESS_C = 2'd1;
   localparam logic [1:0] ST_DONE_C   = 2'd2;

   localparam logic [31:0] POISON_DATA_C = 32'hDEADBEEF;

   localparam logic BUBBLE_REGWRITE_C = 1'b0;
   localparam logic BUBBLE_MEMTOREG_C = 1'b0;

   typedef struct packed {
      logic        memtoreg;
      logic        regwrite;
      logic [31:0] rdata;
      logic [31:0] result;
      logic [4:0]  rd;
   } memwb_t;

   localparam memwb_t MEMWB_RESET_C = '{1'b0, 1'b0, 32'd0, 32'd0, 5'd0};

   function automatic logic word_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

   // A bubble keeps the data fields but must never write the register file.
   function automatic memwb_t memwb_bubble(input memwb_t cur);
      memwb_t nxt;
      nxt          = cur;
      nxt.regwrite = BUBBLE_REGWRITE_C;
      nxt.memtoreg = BUBBLE_MEMTOREG_C;
      return nxt;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory port between the memory stage (master) and the data memory (slave).
interface mem_access_unit_if;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_ack_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_ack_i, mem_rdata_i
   );
endinterface

// File: rtl/mem_timeout_counter.sv
// Ack-wait counter: counts enabled cycles after a clear and flags the
// TERMINAL-th cycle; it saturates there until cleared.
module mem_timeout_counter #(
   parameter int unsigned TERMINAL = 255
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [7:0] LAST_C = 8'(TERMINAL - 1);

   logic [7:0] count_r;

   assign tc_o = (count_r == LAST_C);

   // Wait-cycle count, cleared outside an access
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_r <= 8'd0;
      end else if (clr_i) begin
         count_r <= 8'd0;
      end else if (en_i && !tc_o) begin
         count_r <= count_r + 8'd1;
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: issues one data-memory request per aligned load/store, freezes the
// pipeline until ack or timeout, and drives the MEM/WB register.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              memtoreg_i,
   input  logic              regwrite_i,
   input  logic              memwrite_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       wdata_i,
   input  logic [4:0]        RD_i,
   mem_access_unit_if.master mem,
   output logic              stall_o,
   output logic              memtoreg_o,
   output logic              regwrite_o,
   output logic [31:0]       rdata_o,
   output logic [31:0]       result_o,
   output logic [4:0]        RD_o,
   output logic              misalign_o,
   output logic              timeout_o
);
   import cpu_pkg::*;

   logic [1:0]  state_r;
   logic [1:0]  state_nxt_s;
   logic        access_s;
   logic        start_s;
   logic        misalign_s;
   logic        ack_s;
   logic        expire_s;
   logic        tc_s;
   logic        in_access_s;
   logic [31:0] rbuf_r;
   logic        timeout_r;
   logic        misalign_r;
   memwb_t      memwb_r;

   assign access_s    = memtoreg_i | memwrite_i;
   assign in_access_s = (state_r == ST_ACCESS_C);
   assign start_s     = (state_r == ST_IDLE_C) && access_s && word_aligned(addr_i[1:0]);
   assign misalign_s  = (state_r == ST_IDLE_C) && access_s && !word_aligned(addr_i[1:0]);
   assign ack_s       = in_access_s && mem.mem_ack_i;
   assign expire_s    = in_access_s && !mem.mem_ack_i && tc_s;
   // Reset gates the stall so the pipeline is never frozen while held in reset.
   assign stall_o     = rst_n_i && (start_s || in_access_s);

   mem_timeout_counter #(
      .TERMINAL (TIMEOUT_CYCLES)
   ) u_wait_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (!in_access_s),
      .en_i    (in_access_s),
      .tc_o    (tc_s)
   );

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE_C: begin
            if (start_s) state_nxt_s = ST_ACCESS_C;
            else         state_nxt_s = ST_IDLE_C;
         end
         ST_ACCESS_C: begin
            if (ack_s || expire_s) state_nxt_s = ST_DONE_C;
            else                   state_nxt_s = ST_ACCESS_C;
         end
         ST_DONE_C: state_nxt_s = ST_IDLE_C;
         default:   state_nxt_s = ST_IDLE_C;
      endcase
   end

   // FSM state, memory-port registers, read buffer and status flags
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r         <= ST_IDLE_C;
         mem.mem_req_o   <= 1'b0;
         mem.mem_we_o    <= 1'b0;
         mem.mem_addr_o  <= 32'd0;
         mem.mem_wdata_o <= 32'd0;
         rbuf_r          <= 32'd0;
         timeout_r       <= 1'b0;
         misalign_r      <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         misalign_r <= misalign_s;
         if (start_s) begin
            mem.mem_req_o   <= 1'b1;
            mem.mem_we_o    <= memwrite_i;
            mem.mem_addr_o  <= addr_i;
            mem.mem_wdata_o <= wdata_i;
         end else if (ack_s || expire_s) begin
            mem.mem_req_o <= 1'b0;
            mem.mem_we_o  <= 1'b0;
         end else begin
            mem.mem_req_o <= mem.mem_req_o;
            mem.mem_we_o  <= mem.mem_we_o;
         end
         if (ack_s) begin
            rbuf_r <= mem.mem_rdata_i;
         end else if (expire_s) begin
            rbuf_r    <= POISON_DATA_C;
            timeout_r <= 1'b1;
         end else begin
            rbuf_r <= rbuf_r;
         end
      end
   end

   // MEM/WB register: bubble while stalled, otherwise take the EX/MEM instruction
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         memwb_r <= MEMWB_RESET_C;
      end else if (stall_o) begin
         memwb_r <= memwb_bubble(memwb_r);
      end else begin
         memwb_r.memtoreg <= memtoreg_i;
         memwb_r.regwrite <= regwrite_i && !misalign_s;
         memwb_r.result   <= addr_i;
         memwb_r.rd       <= RD_i;
         if (state_r == ST_DONE_C) memwb_r.rdata <= rbuf_r;
         else                      memwb_r.rdata <= memwb_r.rdata;
      end
   end

   assign memtoreg_o = memwb_r.memtoreg;
   assign regwrite_o = memwb_r.regwrite;
   assign rdata_o    = memwb_r.rdata;
   assign result_o   = memwb_r.result;
   assign RD_o       = memwb_r.rd;
   assign misalign_o = misalign_r;
   assign timeout_o  = timeout_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (built with a 4-cycle ack timeout).
module tb_mem_access_unit;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        memtoreg_i, regwrite_i, memwrite_i;
   logic [31:0] addr_i, wdata_i;
   logic [4:0]  RD_i;
   logic        stall_o, memtoreg_o, regwrite_o, misalign_o, timeout_o;
   logic [31:0] rdata_o, result_o;
   logic [4:0]  RD_o;

   int n_checks = 0;
   int n_pass   = 0;
   int stalls;

   mem_access_unit_if mem_if ();

   mem_access_unit #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .memtoreg_i (memtoreg_i),
      .regwrite_i (regwrite_i),
      .memwrite_i (memwrite_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .RD_i       (RD_i),
      .mem        (mem_if),
      .stall_o    (stall_o),
      .memtoreg_o (memtoreg_o),
      .regwrite_o (regwrite_o),
      .rdata_o    (rdata_o),
      .result_o   (result_o),
      .RD_o       (RD_o),
      .misalign_o (misalign_o),
      .timeout_o  (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_instr(input logic m2r, input logic rw, input logic mw,
                            input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
      memtoreg_i = m2r; regwrite_i = rw; memwrite_i = mw;
      addr_i = a; wdata_i = wd; RD_i = rd;
   endtask

   // Run one access until stall drops; ack_after<0 means never ack.
   // Returns at the DONE cycle, before the edge that loads MEM/WB.
   task automatic run_access(input int ack_after, input logic [31:0] rd_val,
                             input logic exp_we, output int n_stall);
      int waited = 0;
      n_stall = 0;
      for (int c = 0; c < 40; c++) begin
         mem_if.mem_ack_i = 1'b0;
         if (mem_if.mem_req_o) begin
            check_val("port_we", {31'd0, mem_if.mem_we_o}, {31'd0, exp_we});
            check_val("port_addr", mem_if.mem_addr_o, addr_i);
            check_val("port_wdata", mem_if.mem_wdata_o, wdata_i);
            if (waited == ack_after) begin
               mem_if.mem_ack_i   = 1'b1;
               mem_if.mem_rdata_i = rd_val;
            end
            waited++;
         end
         #1;
         if (!stall_o) break;
         n_stall++;
         tick();
         check_val("bubble_rw", {31'd0, regwrite_o}, 32'd0);
      end
      mem_if.mem_ack_i = 1'b0;
   endtask

   initial begin
      rst_n_i = 1'b0;
      mem_if.mem_ack_i   = 1'b0;
      mem_if.mem_rdata_i = 32'd0;
      set_instr(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      #12;
      check_val("rst_stall", {31'd0, stall_o}, 32'd0);
      check_val("rst_req", {31'd0, mem_if.mem_req_o}, 32'd0);
      check_val("rst_addr", mem_if.mem_addr_o, 32'd0);
      check_val("rst_rw", {31'd0, regwrite_o}, 32'd0);
      check_val("rst_rdata", rdata_o, 32'd0);
      check_val("rst_timeout", {31'd0, timeout_o}, 32'd0);
      rst_n_i = 1'b1;
      tick();

      // Back-to-back ALU ops pass with zero stall
      set_instr(1'b0, 1'b1, 1'b0, 32'h0000_00A5, 32'd0, 5'd3);
      #1 check_val("alu1_stall", {31'd0, stall_o}, 32'd0);
      tick();
      check_val("alu1_result", result_o, 32'h0000_00A5);
      check_val("alu1_rd", {27'd0, RD_o}, 32'd3);
      check_val("alu1_rw", {31'd0, regwrite_o}, 32'd1);
      set_instr(1'b0, 1'b1, 1'b0, 32'h0000_0077, 32'd0, 5'd4);
      #1 check_val("alu2_stall", {31'd0, stall_o}, 32'd0);
      tick();
      check_val("alu2_result", result_o, 32'h0000_0077);

      // Load with ack in the first ACCESS cycle
      set_instr(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 5'd5);
      run_access(0, 32'h1234_5678, 1'b0, stalls);
      check_val("load_stalls", stalls, 32'd2);
      tick();
      check_val("load_rdata", rdata_o, 32'h1234_5678);
      check_val("load_rw", {31'd0, regwrite_o}, 32'd1);
      check_val("load_m2r", {31'd0, memtoreg_o}, 32'd1);
      check_val("load_rd", {27'd0, RD_o}, 32'd5);
      check_val("load_result", result_o, 32'h0000_0010);

      // Store acked after 3 wait cycles
      set_instr(1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 5'd0);
      check_val("store_req_idle", {31'd0, mem_if.mem_req_o}, 32'd0);
      run_access(3, 32'd0, 1'b1, stalls);
      check_val("store_stalls", stalls, 32'd5);
      tick();
      check_val("store_rw", {31'd0, regwrite_o}, 32'd0);
      check_val("store_result", result_o, 32'h0000_0020);
      check_val("store_req_after", {31'd0, mem_if.mem_req_o}, 32'd0);

      // Misaligned load: no request, no stall, one-cycle flag, no register write
      set_instr(1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'd0, 5'd7);
      #1;
      check_val("mis_stall", {31'd0, stall_o}, 32'd0);
      check_val("mis_req", {31'd0, mem_if.mem_req_o}, 32'd0);
      tick();
      check_val("mis_flag", {31'd0, misalign_o}, 32'd1);
      check_val("mis_rw", {31'd0, regwrite_o}, 32'd0);
      check_val("mis_result", result_o, 32'h0000_0013);
      set_instr(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      mem_if.mem_ack_i = 1'b1;
      tick();
      mem_if.mem_ack_i = 1'b0;
      check_val("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
      check_val("stray_ack_req", {31'd0, mem_if.mem_req_o}, 32'd0);

      // Load that never gets an ack
      set_instr(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'd0, 5'd9);
      run_access(-1, 32'd0, 1'b0, stalls);
      check_val("to_stalls", stalls, 32'd5);
      check_val("to_flag_done", {31'd0, timeout_o}, 32'd1);
      tick();
      check_val("to_rdata", rdata_o, 32'hDEAD_BEEF);
      set_instr(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      tick();
      tick();
      check_val("to_sticky", {31'd0, timeout_o}, 32'd1);

      // Reset in the middle of an access, then a late ack
      set_instr(1'b1, 1'b1, 1'b0, 32'h0000_0050, 32'd0, 5'd11);
      tick();
      check_val("abort_req_before", {31'd0, mem_if.mem_req_o}, 32'd1);
      rst_n_i = 1'b0;
      #1;
      check_val("abort_req", {31'd0, mem_if.mem_req_o}, 32'd0);
      check_val("abort_stall", {31'd0, stall_o}, 32'd0);
      check_val("abort_timeout", {31'd0, timeout_o}, 32'd0);
      mem_if.mem_ack_i   = 1'b1;
      mem_if.mem_rdata_i = 32'h0000_0099;
      tick();
      check_val("abort_rw", {31'd0, regwrite_o}, 32'd0);
      check_val("abort_rd", {27'd0, RD_o}, 32'd0);
      set_instr(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      mem_if.mem_ack_i = 1'b0;
      rst_n_i = 1'b1;
      tick();
      check_val("abort_rdata", rdata_o, 32'd0);
      check_val("abort_req_after", {31'd0, mem_if.mem_req_o}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max ack-wait cycles (range 1..255).
REQ-002 SHALL have ports clk_i in 1 (system clock) and rst_n_i in 1: one clock; reset asynchronous, active-low.
REQ-003 SHALL have memtoreg_i in 1 (load), regwrite_i in 1, memwrite_i in 1 (store); all from the EX/MEM register.
REQ-004 SHALL have addr_i in 32 (ALU result/address), wdata_i in 32 (store data), RD_i in 5 (destination register).
REQ-005 SHALL have mem_req_o out 1, mem_we_o out 1, mem_addr_o out 32, mem_wdata_o out 32, mem_ack_i in 1, mem_rdata_i in 32 (data-memory port).
REQ-006 SHALL have stall_o out 1 (freeze PC, IF/ID, ID/EX, EX/MEM).
REQ-007 SHALL have memtoreg_o out 1, regwrite_o out 1, rdata_o out 32, result_o out 32, RD_o out 5 (MEM/WB register outputs).
REQ-008 SHALL have misalign_o out 1 (one-cycle pulse) and timeout_o out 1 (sticky).

Function
REQ-009 SHALL define access = memtoreg_i | memwrite_i; memwrite_i has priority (both set -> store, rdata_o undefined).
REQ-010 SHALL implement FSM IDLE, ACCESS, DONE.
REQ-011 IDLE: aligned access (addr_i[1:0]==0) -> ACCESS at next edge; otherwise stay.
REQ-012 ACCESS: mem_req_o=1, mem_we_o=memwrite_i, mem_addr_o=addr_i, mem_wdata_o=wdata_i, all held stable until ack.
REQ-013 ACCESS: mem_ack_i=1 -> latch mem_rdata_i into read buffer, go DONE.
REQ-014 ACCESS: wait counter reaching TIMEOUT_CYCLES without ack -> buffer=32'hDEADBEEF, timeout_o=1, go DONE.
REQ-015 DONE -> IDLE unconditionally after one cycle; no request issued in DONE.
REQ-016 stall_o SHALL be combinational: 1 when (IDLE and aligned access) or ACCESS; 0 in DONE and for non-access.
REQ-017 mem_req_o SHALL be 0 outside ACCESS; at most one request per instruction.
REQ-018 When stall_o=0 at a rising edge, the MEM/WB outputs SHALL load memtoreg_i, regwrite_i, addr_i->result_o, RD_i, and rdata_o (buffer when DONE, else unchanged).
REQ-019 When stall_o=1 at an edge, the MEM/WB outputs SHALL load a bubble: regwrite_o=0, memtoreg_o=0, other fields held.
REQ-020 Misaligned access in IDLE: no request, no stall, misalign_o=1 for that cycle, and the instruction's regwrite_o SHALL load as 0.
REQ-021 Latency: an ack in the first ACCESS cycle yields 2 stall cycles; every additional wait cycle adds one stall cycle.
REQ-022 A non-access instruction SHALL pass through in one cycle with zero stall.
REQ-023 mem_ack_i outside ACCESS SHALL be ignored.

Reset
REQ-024 rst_n_i low SHALL asynchronously force IDLE, mem_req_o=0, mem_we_o=0, stall_o=0, counter=0, timeout_o=0.
REQ-025 Reset SHALL clear memtoreg_o=0, regwrite_o=0, rdata_o=0, result_o=0, RD_o=0, misalign_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-026 Reset asserted mid-ACCESS SHALL abandon the transaction; a late ack SHALL be ignored.

Structure
REQ-027 FSM state encoding, 32'hDEADBEEF poison constant and bubble defaults SHALL live in shared package cpu_pkg.
REQ-028 The wait counter SHALL be sub-module mem_timeout_counter (clear, enable, terminal-count output).

Verification
REQ-029 Load addr=0x10, ack on 1st ACCESS cycle, rdata=0x12345678 -> 2 stall cycles; rdata_o=0x12345678, regwrite_o=1, RD_o as issued.
REQ-030 Store addr=0x20, wdata=0xCAFEF00D, ack after 3 wait cycles -> mem_we_o=1 with stable addr/data, 5 stall cycles, regwrite_o=regwrite_i.
REQ-031 Load addr=0x13 -> no mem_req_o, stall_o=0, misalign_o single pulse, regwrite_o=0.
REQ-032 Load, TIMEOUT_CYCLES=4, no ack -> DONE after 4 wait cycles, rdata_o=0xDEADBEEF, timeout_o=1 until reset.
REQ-033 rst_n_i low during ACCESS, then ack -> mem_req_o=0 immediately, state IDLE, no MEM/WB update.
REQ-034 Back-to-back ALU ops then load -> zero stall for the ALU ops; regwrite_o bubble=0 on each stalled edge.
